generador_tablero: RTL

GENERADOR_TABLERO -- requirements
Module: generador_tablero

---
 rtl/buscaminas_pkg.sv | 22 ++
 rtl/lfsr_tablero.sv | 22 ++
 rtl/generador_tablero.sv | 118 +++++++++++
 3 files changed

// File: rtl/buscaminas_pkg.sv
// Shared definitions for the minesweeper board generator and game logic stage.
package buscaminas_pkg;

   typedef logic [3:0] cell_t;

   localparam cell_t      CELL_HIDDEN = 4'h0;
   localparam cell_t      CELL_BOMB   = 4'hB;
   localparam logic [7:0] LFSR_SEED   = 8'hA5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      PLACE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One Fibonacci step for x^8+x^6+x^5+x^4+1 (maximal length, never reaches 0 from a non-zero seed).
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

endpackage

// File: rtl/lfsr_tablero.sv
// Free-running 8-bit LFSR that supplies candidate bomb positions.
module lfsr_tablero
   import buscaminas_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] q
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   assign lfsr_d = lfsr_next(lfsr_q);
   assign q      = lfsr_q;

   // Advance every clock; reset reloads the seed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/generador_tablero.sv
// Board generator: clears the 8x8 board, then scatters the requested number of
// bombs at pseudo-random positions, avoiding the player's first (safe) cell.
module generador_tablero
   import buscaminas_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] bombas,
   input  logic [2:0] safe_x,
   input  logic [2:0] safe_y,
   output logic [3:0] tablero [8][8],
   output logic       busy,
   output logic       done,
   output logic [3:0] bomb_count
);

   state_t     state_q, state_d;
   logic [3:0] target_q, target_d;
   logic [2:0] safe_x_q, safe_x_d;
   logic [2:0] safe_y_q, safe_y_d;
   logic [3:0] count_q, count_d;
   cell_t      tablero_q [8][8];
   cell_t      tablero_d [8][8];

   logic [7:0] lfsr_q;
   logic [1:0] lfsr_unused;
   logic [2:0] cand_x;
   logic [2:0] cand_y;
   logic       cand_ok;
   logic [3:0] count_inc;

   lfsr_tablero u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   // Only the low six bits form the cell index.
   assign lfsr_unused = lfsr_q[7:6];
   assign cand_x      = lfsr_q[5:3];
   assign cand_y      = lfsr_q[2:0];
   assign cand_ok     = (tablero_q[cand_x][cand_y] != CELL_BOMB) &&
                        !((cand_x == safe_x_q) && (cand_y == safe_y_q));
   assign count_inc   = count_q + 4'd1;

   // Outputs are decoded from registered state only.
   assign busy       = (state_q == CLEAR) || (state_q == PLACE);
   assign done       = (state_q == DONE);
   assign bomb_count = count_q;
   assign tablero    = tablero_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and next board contents.
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      safe_x_d  = safe_x_q;
      safe_y_d  = safe_y_q;
      count_d   = count_q;
      tablero_d = tablero_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               target_d = (bombas == 4'd0) ? 4'd1 : bombas;
               safe_x_d = safe_x;
               safe_y_d = safe_y;
               state_d  = CLEAR;
            end
         end
         CLEAR: begin
            for (int i = 0; i < 8; i++) begin
               for (int j = 0; j < 8; j++) begin
                  tablero_d[i][j] = CELL_HIDDEN;
               end
            end
            count_d = 4'd0;
            state_d = PLACE;
         end
         PLACE: begin
            // A rejected candidate simply waits for the next LFSR value.
            if (cand_ok) begin
               tablero_d[cand_x][cand_y] = CELL_BOMB;
               count_d                   = count_inc;
               if (count_inc == target_q) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers: request parameters, bomb counter and board.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_q <= 4'd1;
         safe_x_q <= 3'd0;
         safe_y_q <= 3'd0;
         count_q  <= 4'd0;
         for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
               tablero_q[i][j] <= CELL_HIDDEN;
            end
         end
      end else begin
         target_q  <= target_d;
         safe_x_q  <= safe_x_d;
         safe_y_q  <= safe_y_d;
         count_q   <= count_d;
         tablero_q <= tablero_d;
      end
   end

endmodule
